// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-memory load/store interface: one request
// at a time, byte/half/word access on a word-organised RAM, response after LATENCY cycles.
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [0:(1 << ADDR_W) - 1];

    logic               accept;
    logic [ADDR_W-1:0]  word_idx;
    logic               out_of_range;
    logic               illegal;
    logic               misaligned;
    logic               access_err;
    logic [31:0]        rd_word;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        load_val;
    logic [3:0]         byte_en;
    logic [31:0]        wr_lanes;
    logic               wr_en;

    // Request decode: legality, alignment, load extension and store lane steering.
    always_comb begin
        accept       = (state_q == S_IDLE) && req_valid;
        word_idx     = req_addr[ADDR_W+1:2];
        out_of_range = |req_addr[31:ADDR_W+2];
        illegal      = 1'b0;
        misaligned   = 1'b0;
        load_val     = 32'd0;
        byte_en      = 4'b0000;
        wr_lanes     = req_wdata;
        rd_word      = mem[word_idx];

        case (req_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (req_op)
            3'b000: begin
                load_val = {{24{rd_byte[7]}}, rd_byte};
                byte_en  = 4'b0001 << req_addr[1:0];
                wr_lanes = {4{req_wdata[7:0]}};
            end
            3'b001: begin
                misaligned = req_addr[0];
                load_val   = {{16{rd_half[15]}}, rd_half};
                byte_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes   = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                misaligned = |req_addr[1:0];
                load_val   = rd_word;
                byte_en    = 4'b1111;
            end
            3'b100: begin
                illegal  = req_wr;
                load_val = {24'd0, rd_byte};
            end
            3'b101: begin
                illegal    = req_wr;
                misaligned = req_addr[0];
                load_val   = {16'd0, rd_half};
            end
            default: illegal = 1'b1;
        endcase

        access_err = illegal || misaligned || out_of_range;
        wr_en      = accept && req_wr && !access_err;
    end

    // Next-state logic; the load result is captured at the acceptance edge and held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rdata_d = (req_wr || access_err) ? 32'd0 : load_val;
                    err_d   = access_err;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        rsp_rdata = rsp_valid ? rdata_q : 32'd0;
        rsp_err   = rsp_valid && err_q;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: a LATENCY=2 instance for the functional scenarios
// and a LATENCY=1 instance for back-to-back throughput, both against a byte-level model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic [2:0]  req_op = 3'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1 = 1'b0, req_wr1 = 1'b0, rsp_ready1 = 1'b1;
    logic [31:0] req_addr1 = 32'd0, req_wdata1 = 32'd0;
    logic [2:0]  req_op1 = 3'd0;
    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    logic [31:0] ref_mem0 [0:1023];
    logic [31:0] ref_mem1 [0:1023];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
        .req_addr(req_addr1), .req_op(req_op1), .req_wdata(req_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    // Reference model: access size/sign from funct3, memory as plain byte arithmetic.
    function automatic void model(input int sel, input bit wr, input logic [31:0] addr,
                                  input logic [2:0] op, input logic [31:0] wd,
                                  output logic [31:0] rd, output bit err);
        int          size;
        bit          uns;
        bit          illegal;
        int          idx;
        int          off;
        logic [31:0] word;
        logic [31:0] mask;
        logic [31:0] val;
        size = 1; uns = 0; illegal = 0; rd = 32'd0;
        case (op)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            3'd4: begin size = 1; uns = 1; end
            3'd5: begin size = 2; uns = 1; end
            default: illegal = 1;
        endcase
        if (wr && uns) illegal = 1;
        err = illegal || (addr % size != 0) || (addr >= 32'd4096);
        if (err) return;
        idx  = int'(addr / 4);
        off  = int'(addr % 4);
        word = (sel == 0) ? ref_mem0[idx] : ref_mem1[idx];
        if (wr) begin
            for (int k = 0; k < size; k++) word[8*(off+k) +: 8] = wd[8*k +: 8];
            if (sel == 0) ref_mem0[idx] = word; else ref_mem1[idx] = word;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
            val  = (word >> (8*off)) & mask;
            if (!uns && size < 4 && val[8*size-1]) val = val | ~mask;
            rd = val;
        end
    endfunction

    // Issue one request to the LATENCY=2 instance; lat counts cycles to rsp_valid (99 = timeout).
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [2:0] op,
                          input logic [31:0] wd, input bit ready,
                          output logic [31:0] rd, output logic err, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_op = op; req_wdata = wd;
        rsp_ready = ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_wr = 1'($urandom); req_addr = $urandom;
        req_op = 3'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rd  = rsp_rdata;
        err = rsp_err;
        if (ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("[TB] FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_err got=%b want=0", rsp_err); end
        total++; if (req_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_lat1 got ready=%b valid=%b want 1/0", req_ready1, rsp_valid1);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word;
        logic [31:0] rd, exp_rd;
        logic        err;
        bit          exp_err;
        int          lat;
        model(0, 1, 32'h10, 3'd2, 32'hDEAD_BEEF, exp_rd, exp_err);
        do_req(1, 32'h10, 3'd2, 32'hDEAD_BEEF, 1, rd, err, lat);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL sw_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'd0 || err !== 1'b0) begin bad++; $display("[TB] FAIL sw_rsp got=%h/%b want=0/0", rd, err); end
        do_req(0, 32'h10, 3'd2, 32'd0, 1, rd, err, lat);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL lw_latency got=%0d want=2", lat); end
        total++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin bad++; $display("[TB] FAIL lw_rsp got=%h/%b want=deadbeef/0", rd, err); end
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL lw_idle got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_extension;
        logic [31:0] addrs [7] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h10, 32'h12};
        logic [2:0]  ops   [7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd0, 3'd2, 3'd5};
        bit          wrs   [7] = '{0, 0, 0, 0, 1, 0, 0};
        logic [31:0] wds   [7] = '{0, 0, 0, 0, 32'h0000_0055, 0, 0};
        logic [31:0] exps  [7] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF,
                                   32'h0, 32'hDEAD_55EF, 32'h0000_DEAD};
        logic [31:0] rd, mrd;
        logic        err;
        bit          merr;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            model(0, wrs[i], addrs[i], ops[i], wds[i], mrd, merr);
            do_req(wrs[i], addrs[i], ops[i], wds[i], 1, rd, err, lat);
            total++; if (rd !== exps[i] || err !== 1'b0) begin
                bad++; $display("[TB] FAIL ext_%0d got=%h/%b want=%h/0", i, rd, err, exps[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [31:0] addrs [5] = '{32'h12, 32'h11, 32'h10, 32'h0000_1000, 32'h10};
        logic [2:0]  ops   [5] = '{3'd2, 3'd1, 3'd2, 3'd2, 3'd3};
        bit          wrs   [5] = '{0, 1, 0, 0, 0};
        bit          errs  [5] = '{1, 1, 0, 1, 1};
        logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'hDEAD_55EF, 32'h0, 32'h0};
        logic [31:0] rd, mrd;
        logic        err;
        bit          merr;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            model(0, wrs[i], addrs[i], ops[i], 32'h0000_1234, mrd, merr);
            do_req(wrs[i], addrs[i], ops[i], 32'h0000_1234, 1, rd, err, lat);
            total++; if (rd !== exps[i] || err !== errs[i]) begin
                bad++; $display("[TB] FAIL err_%0d got=%h/%b want=%h/%b", i, rd, err, exps[i], errs[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd;
        logic        err;
        int          lat;
        do_req(0, 32'h10, 3'd2, 32'd0, 0, rd, err, lat);
        total++; if (lat !== 2 || rd !== 32'hDEAD_55EF) begin
            bad++; $display("[TB] FAIL bp_first got lat=%0d rd=%h want 2/dead55ef", lat, rd);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_55EF || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                bad++; $display("[TB] FAIL bp_hold_%0d got v=%b d=%h e=%b r=%b want 1/dead55ef/0/0",
                                i, rsp_valid, rsp_rdata, rsp_err, req_ready);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL bp_release got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, mrd;
        logic        err;
        bit          merr;
        int          lat;
        int          seen;
        model(0, 1, 32'h20, 3'd2, 32'h1357_9BDF, mrd, merr);
        do_req(1, 32'h20, 3'd2, 32'h1357_9BDF, 1, rd, err, lat);

        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h20; req_op = 3'd2; rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_wait_ready got=%b want=0", req_ready); end
        #1 rst = 1'b0;
        #1;
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_reset got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;

        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h24; req_op = 3'd2; req_wdata = 32'hA5A5_0F0F;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(0, 1, 32'h24, 3'd2, 32'hA5A5_0F0F, mrd, merr);
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL mid_no_rsp got=%0d want=0", seen); end

        do_req(0, 32'h20, 3'd2, 32'd0, 1, rd, err, lat);
        total++; if (rd !== 32'h1357_9BDF || err !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_retain got=%h/%b want=13579bdf/0", rd, err);
        end
        do_req(0, 32'h24, 3'd2, 32'd0, 1, rd, err, lat);
        total++; if (rd !== 32'hA5A5_0F0F || err !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_committed got=%h/%b want=a5a50f0f/0", rd, err);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, mrd, addr, wd;
        logic [2:0]  op;
        logic        err;
        bit          merr, wr;
        int          lat;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model(0, 1, 32'(w * 4), 3'd2, wd, mrd, merr);
            do_req(1, 32'(w * 4), 3'd2, wd, 1, rd, err, lat);
        end
        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? (32'h1000 + 32'($urandom_range(0, 63))) : 32'($urandom_range(0, 63));
            wd   = $urandom;
            model(0, wr, addr, op, wd, mrd, merr);
            do_req(wr, addr, op, wd, 1, rd, err, lat);
            total++; if (rd !== mrd || err !== merr || lat !== 2) begin
                bad++; $display("[TB] FAIL rand_%0d wr=%b op=%0d addr=%h got=%h/%b/%0d want=%h/%b/2",
                                i, wr, op, addr, rd, err, lat, mrd, merr);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [31:0] mrd, addr, wd;
        logic [2:0]  op;
        bit          merr, wr;
        int          acc, prev, n, off;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            if (i < 4) begin
                wr = 1; op = 3'd2; addr = 32'(i * 4); wd = $urandom;
            end else begin
                wr = 0; op = ops[$urandom_range(0, 4)]; wd = $urandom;
                off = $urandom_range(0, 3);
                if (op == 3'd2) off = 0;
                else if (op == 3'd1 || op == 3'd5) off = off & 2;
                addr = 32'($urandom_range(0, 3) * 4 + off);
            end
            @(negedge clk);
            n = 0;
            while (!req_ready1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            req_valid1 = 1'b1; req_wr1 = wr; req_addr1 = addr; req_op1 = op; req_wdata1 = wd;
            model(1, wr, addr, op, wd, mrd, merr);
            @(posedge clk);
            #1;
            acc = cyc;
            total++; if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== mrd || rsp_err1 !== merr) begin
                bad++; $display("[TB] FAIL b2b_%0d got v=%b d=%h e=%b want 1/%h/%b", i, rsp_valid1, rsp_rdata1, rsp_err1, mrd, merr);
            end
            if (i > 0) begin
                total++; if (acc - prev !== 2) begin
                    bad++; $display("[TB] FAIL b2b_spacing_%0d got=%0d want=2", i, acc - prev);
                end
            end
            prev = acc;
        end
        @(negedge clk);
        req_valid1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_extension();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
